rsa_job_arbiter: RTL and testbench

Round-robin job scheduler that shares one `rsa4k` modular-exponentiation engine between `N_REQ` requesters. It accepts one job at a time and registers the winning requester's operands onto the engine inputs. It pulses the engine `go`, tracks the engine `done` handshake with a watchdog, and returns the result or a timeout error to the requester that submitted the job. It sits between the host-side job queues and the single `rsa4k` instance.

---
 rtl/rsa_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 27 ++
 rtl/rsa_job_arbiter.sv | 134 +++++++++++++
 tb/tb_rsa_job_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_arb_pkg.sv
// Shared definitions for the rsa4k job arbiter: FSM state encoding and the
// default watchdog limit.
`ifndef RSA_WIDTH
`define RSA_WIDTH 4096
`endif

package rsa_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [31:0] TIMEOUT_DEFAULT = 32'd50_000_000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after
// `last` (wrapping) wins; returns both one-hot and index forms.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = |req;
    // Scan farthest-first so the requester nearest after `last` overrides.
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        win_idx = IW'((int'(last) + k) % N);
        win_oh  = N'(1) << ((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one rsa4k engine between N_REQ requesters: round-robin job pick,
// registered operands, go/done handshake with a saturating watchdog.
`ifndef RSA_WIDTH
`define RSA_WIDTH 4096
`endif

module rsa_job_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter int          RSA_WIDTH      = `RSA_WIDTH,
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*RSA_WIDTH-1:0] req_message,
  input  logic [N_REQ*RSA_WIDTH-1:0] req_exponent,
  input  logic [N_REQ*RSA_WIDTH-1:0] req_modulus,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic                       rsp_error,
  output logic [RSA_WIDTH-1:0]       rsp_data,
  output logic                       busy,
  output logic                       eng_reset,
  output logic                       eng_go,
  output logic [RSA_WIDTH-1:0]       eng_message,
  output logic [RSA_WIDTH-1:0]       eng_exponent,
  output logic [RSA_WIDTH-1:0]       eng_modulus,
  input  logic [RSA_WIDTH-1:0]       eng_cypher,
  input  logic                       eng_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   idx;
  logic [31:0]     wd;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            wd_expired;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  assign busy       = (state != ST_IDLE);
  assign wd_expired = (wd == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      last         <= IW'(N_REQ - 1);
      idx          <= '0;
      wd           <= '0;
      grant        <= '0;
      rsp_valid    <= '0;
      rsp_error    <= 1'b0;
      rsp_data     <= '0;
      eng_reset    <= 1'b1;
      eng_go       <= 1'b0;
      eng_message  <= '0;
      eng_exponent <= '0;
      eng_modulus  <= '0;
    end else begin
      eng_reset <= 1'b0;
      eng_go    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            eng_message  <= req_message [int'(win_idx)*RSA_WIDTH +: RSA_WIDTH];
            eng_exponent <= req_exponent[int'(win_idx)*RSA_WIDTH +: RSA_WIDTH];
            eng_modulus  <= req_modulus [int'(win_idx)*RSA_WIDTH +: RSA_WIDTH];
            grant        <= win_oh;
            idx          <= win_idx;
            eng_go       <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd    <= '0;
          state <= ST_ARM;
        end
        ST_ARM: begin
          // A done still high from the previous job is not a completion.
          if (wd_expired) begin
            eng_reset <= 1'b1;
            rsp_valid <= grant;
            rsp_error <= 1'b1;
            state     <= ST_ABORT;
          end else begin
            if (!eng_done) state <= ST_RUN;
            if (wd != '1) wd <= wd + 32'd1;
          end
        end
        ST_RUN: begin
          if (eng_done) begin
            rsp_data  <= eng_cypher;
            rsp_valid <= grant;
            rsp_error <= 1'b0;
            state     <= ST_RESP;
          end else if (wd_expired) begin
            eng_reset <= 1'b1;
            rsp_valid <= grant;
            rsp_error <= 1'b1;
            state     <= ST_ABORT;
          end else if (wd != '1) begin
            wd <= wd + 32'd1;
          end
        end
        ST_RESP: begin
          grant <= '0;
          last  <= idx;
          state <= ST_IDLE;
        end
        ST_ABORT: begin
          grant     <= '0;
          rsp_error <= 1'b0;
          last      <= idx;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Scoreboard bench for rsa_job_arbiter with a programmable-latency rsa4k stub.
module tb_rsa_job_arbiter;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int TMO = 100;

  typedef struct {
    int          idx;
    bit          err;
    logic [W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N*W-1:0]     req_message = '0;
  logic [N*W-1:0]     req_exponent = '0;
  logic [N*W-1:0]     req_modulus = '0;
  logic [N-1:0]       grant;
  logic [N-1:0]       rsp_valid;
  logic               rsp_error;
  logic [W-1:0]       rsp_data;
  logic               busy;
  logic               eng_reset;
  logic               eng_go;
  logic [W-1:0]       eng_message;
  logic [W-1:0]       eng_exponent;
  logic [W-1:0]       eng_modulus;
  logic [W-1:0]       eng_cypher = '0;
  logic               eng_done = 1'b0;

  rsa_job_arbiter #(.N_REQ(N), .RSA_WIDTH(W), .TIMEOUT_CYCLES(32'(TMO))) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_message(req_message), .req_exponent(req_exponent), .req_modulus(req_modulus),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .busy(busy), .eng_reset(eng_reset), .eng_go(eng_go),
    .eng_message(eng_message), .eng_exponent(eng_exponent), .eng_modulus(eng_modulus),
    .eng_cypher(eng_cypher), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  int model_last = N - 1;
  logic [W-1:0] last_good = '0;
  logic [W-1:0] msg[N];
  logic [W-1:0] ex[N];
  logic [W-1:0] md[N];

  function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [W-1:0] r = 1;
    for (longint k = 0; k < longint'(e); k++) r = (r * m) % n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // rsa4k stub: result appears lat cycles after go; done drops clr cycles
  // after go (0 = at go) and otherwise stays high until the next go.
  int stub_lat = 5;
  int stub_clr = 0;
  int s_cnt = 0;
  int s_clr = 0;
  logic [W-1:0] s_res = '0;

  always @(posedge clk) begin
    if (eng_reset) begin
      eng_done <= 1'b0;
      s_cnt    <= 0;
      s_clr    <= 0;
    end else if (eng_go) begin
      s_res <= modexp(eng_message, eng_exponent, eng_modulus);
      s_cnt <= stub_lat;
      s_clr <= stub_clr;
      if (stub_clr == 0) eng_done <= 1'b0;
    end else begin
      if (s_clr == 1) eng_done <= 1'b0;
      if (s_clr > 0) s_clr <= s_clr - 1;
      if (s_cnt == 1) begin
        eng_done   <= 1'b1;
        eng_cypher <= s_res;
      end
      if (s_cnt > 0) s_cnt <= s_cnt - 1;
    end
  end

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e.idx);
        chk("rsp_error", 64'(rsp_error), 64'(mon_e.err));
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        if (mon_e.err) chk("eng_reset_on_err", 64'(eng_reset), 64'd1);
        else           chk("grant_in_resp", 64'(grant), 64'(1) << mon_e.idx);
      end
    end
  end

  // Requester contract: drop req_valid once its response has been seen.
  task automatic step();
    @(negedge clk);
    req_valid = req_valid & ~rsp_valid;
  endtask

  task automatic set_ops(input int i);
    md[i]  = W'($urandom_range(3, 1000));
    msg[i] = W'($urandom_range(0, int'(md[i]) - 1));
    ex[i]  = W'($urandom_range(1, 20));
    req_message [i*W +: W] = msg[i];
    req_exponent[i*W +: W] = ex[i];
    req_modulus [i*W +: W] = md[i];
  endtask

  task automatic push_ok(input int i);
    exp_t e;
    e.idx = i; e.err = 1'b0; e.data = modexp(msg[i], ex[i], md[i]);
    sb.push_back(e);
    last_good  = e.data;
    model_last = i;
  endtask

  // Reference ordering: all simultaneously pending requests are served in
  // cyclic order starting just after the last served requester.
  task automatic push_order(input logic [N-1:0] m);
    int base = model_last;
    for (int k = 1; k <= N; k++)
      if (m[(base + k) % N]) push_ok((base + k) % N);
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && c < bound) begin
      step();
      c++;
    end
    chk("drain_in_time", 64'(c < bound), 64'd1);
  endtask

  task automatic job(input int i, input int lat, input int clr, input bit timeout);
    int cyc;
    logic [W-1:0] orig;
    exp_t e;
    set_ops(i);
    stub_lat = lat;
    stub_clr = clr;
    if (timeout) begin
      e.idx = i; e.err = 1'b1; e.data = last_good;
      sb.push_back(e);
      model_last = i;
    end else begin
      push_ok(i);
    end
    req_valid[i] = 1'b1;
    step();
    chk("go_cycle1", 64'(eng_go), 64'd1);
    chk("grant_cycle1", 64'(grant), 64'(1) << i);
    chk("busy_cycle1", 64'(busy), 64'd1);
    orig = msg[i];
    req_message[i*W +: W] = ~orig;
    step();
    cyc = 2;
    chk("go_cycle2", 64'(eng_go), 64'd0);
    chk("eng_message_hold", 64'(eng_message), 64'(orig));
    while (rsp_valid == '0 && cyc < 400) begin
      step();
      cyc++;
    end
    chk("rsp_cycle", 64'(cyc), timeout ? 64'(TMO + 3) : 64'(lat + 3));
    chk("eng_message_hold_end", 64'(eng_message), 64'(orig));
    req_message[i*W +: W] = orig;
    wait_idle(100);
  endtask

  task automatic rand_round();
    logic [N-1:0] m;
    m = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) if (m[i]) set_ops(i);
    stub_lat = $urandom_range(3, 15);
    stub_clr = 0;
    push_order(m);
    req_valid = m;
    wait_idle(2000);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_eng_go"}, 64'(eng_go), 64'd0);
    chk({tag, "_eng_ops"}, 64'(eng_message | eng_exponent | eng_modulus), 64'd0);
    chk({tag, "_eng_reset"}, 64'(eng_reset), 64'd1);
  endtask

  initial begin
    bit seen0, re0;
    int c;
    for (int i = 0; i < N; i++) set_ops(i);
    reset_n = 1'b0;
    repeat (3) step();
    chk_reset_outputs("por");
    reset_n = 1'b1;
    step();
    chk("eng_reset_release", 64'(eng_reset), 64'd0);

    // Contention 0,1,3 from reset pointer; 0 re-asserted after its response.
    stub_lat = 6;
    stub_clr = 0;
    push_order(4'b1011);
    req_valid = 4'b1011;
    seen0 = 0; re0 = 0; c = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && c < 3000) begin
      step();
      c++;
      if (seen0 && !re0) begin
        set_ops(0);
        req_valid[0] = 1'b1;
        push_ok(0);
        re0 = 1;
      end
      if (rsp_valid[0]) seen0 = 1;
    end
    chk("contention_drain", 64'(c < 3000), 64'd1);

    // Single directed job: req 2, 5^3 mod 33 = 26, latency 20.
    job(2, 20, 0, 1'b0);
    req_message[2*W +: W] = 64'd5; req_exponent[2*W +: W] = 64'd3;
    req_modulus[2*W +: W] = 64'd33;
    begin
      exp_t e;
      e.idx = 2; e.err = 1'b0; e.data = 64'd26;
      sb.push_back(e);
      last_good = 64'd26; model_last = 2;
      stub_lat = 20; stub_clr = 0;
      msg[2] = 64'd5; ex[2] = 64'd3; md[2] = 64'd33;
      req_valid[2] = 1'b1;
      c = 0;
      while (rsp_valid == '0 && c < 100) begin step(); c++; end
      chk("single_rsp_cycle", 64'(c), 64'd23);
      wait_idle(100);
    end

    // Stale done held high into the next job, dropping 3 cycles after go.
    job(1, 10, 3, 1'b0);

    repeat (8) rand_round();

    // Watchdog abort, then normal service resumes.
    job($urandom_range(0, N - 1), 0, 0, 1'b1);
    rand_round();

    // Reset in the middle of RUN discards the job silently.
    set_ops(1);
    stub_lat = 30;
    stub_clr = 0;
    req_valid = 4'b0010;
    repeat (10) step();
    chk("busy_before_reset", 64'(busy), 64'd1);
    reset_n = 1'b0;
    req_valid = '0;
    step();
    chk_reset_outputs("midjob");
    step();
    reset_n = 1'b1;
    step();
    chk("eng_reset_release2", 64'(eng_reset), 64'd0);
    model_last = N - 1;
    last_good  = '0;
    repeat (40) step();
    rand_round();
    rand_round();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
